pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the pipeline fetch stage; next generation of the PC+1 incrementer.
- Holds the PC register and selects next PC from: sequential increment by STEP, branch redirect, jump/call target, or return address.
- Return address comes from an internal return-address stack (RAS).
- Supports stall hold and modulo-2^WIDTH wrap-around.

Parameters:
- WIDTH, 32, PC width in bits.
- STEP, 1, sequential increment (1 = word-addressed memory, 4 = byte-addressed).
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC (fetch stall).
- branch_taken_i  in  1  resolved-branch redirect from a later stage.
- branch_target_i  in  WIDTH  branch target.
- jump_i  in  1  unconditional jump.
- call_i  in  1  jump and push return address.
- ret_i  in  1  return: load popped address.
- jump_target_i  in  WIDTH  target for jump_i/call_i.
- pc_o  out  WIDTH  current PC (registered).
- pc_plus_o  out  WIDTH  pc_o+STEP, combinational, truncated to WIDTH.
- ras_count_o  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow_o  out  1  one-cycle pulse: push while full.
- ras_underflow_o  out  1  one-cycle pulse: pop while empty.

Behaviour:
- Reset (async assert, sync release): pc_o=RESET_PC, ras_count_o=0, RAS pointer=0, pulses=0. RAS entry contents don't care.
- Next-PC priority, evaluated each rising edge:
  1. branch_taken_i: pc<=branch_target_i. Overrides stall, jump, call and ret. RAS untouched; jump/call/ret that cycle are squashed.
  2. stall_i: pc holds. RAS untouched; jump/call/ret ignored.
  3. ret_i: if count>0, pc<=top entry, pointer--, count--. If count==0, pc<=pc+STEP and ras_underflow_o=1 next cycle.
  4. call_i: push pc+STEP, pc<=jump_target_i, count++. At count==RAS_DEPTH: circular overwrite of oldest entry, count stays RAS_DEPTH, ras_overflow_o=1 next cycle.
  5. jump_i: pc<=jump_target_i.
  6. Otherwise pc<=pc+STEP.
- call_i and ret_i together (no branch/stall): ret wins, no push.
- call_i and jump_i together: call semantics.
- Arithmetic: all adds modulo 2^WIDTH. RESET_PC and STEP are truncated to WIDTH.
- RAS: circular buffer, write pointer wraps mod RAS_DEPTH. Top = pointer-1. A pop after an overflow returns the most recent pushes in LIFO order; the overwritten entry is lost.
- Pulses: registered, high exactly one cycle after the causing edge, cleared otherwise. A stall or branch in the same cycle suppresses the pulse.
- Latency: redirect visible on pc_o one cycle after the request edge. pc_plus_o tracks pc_o with zero delay.
- Reset mid-operation: immediate return to reset state regardless of stall or pending requests.

Test Plan:
- Reset then free-run, WIDTH=32, STEP=1, RESET_PC=0x100 -> pc_o = 0x100, 0x101, 0x102…; pc_plus_o always pc_o+1.
- PC=0x200, stall_i high 3 cycles with jump_i=1 and target 0x400 -> pc_o stays 0x200 for 3 cycles; then pc resumes sequentially from 0x200 (jump ignored while stalled).
- stall_i=1 and branch_taken_i=1 (target 0x80) on the same edge -> pc_o=0x80 next cycle. Same edge with call_i=1 -> ras_count_o unchanged.
- At PC=0x10, call to 0x50; at 0x52, call to 0x90; then ret, ret -> pc_o=0x53 then 0x11; count 0→1→2→1→0; no pulses.
- RAS_DEPTH=4: five calls from PCs A..E -> ras_overflow_o pulses once, count=4. Four rets return E+1, D+1, C+1, B+1. A fifth ret -> ras_underflow_o pulses and pc=pc+STEP.
- WIDTH=8, STEP=4, pc=0xFC -> next pc_o=0x00 (wrap). Assert rst_n low mid-run -> pc_o=RESET_PC immediately, count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with branch/jump/call/return and return-address stack
module pc_sequencer #(
   parameter int unsigned     WIDTH     = 32,
   parameter longint unsigned STEP      = 1,
   parameter longint unsigned RESET_PC  = 0,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall_i,
   input  logic                       branch_taken_i,
   input  logic [WIDTH-1:0]           branch_target_i,
   input  logic                       jump_i,
   input  logic                       call_i,
   input  logic                       ret_i,
   input  logic [WIDTH-1:0]           jump_target_i,
   output logic [WIDTH-1:0]           pc_o,
   output logic [WIDTH-1:0]           pc_plus_o,
   output logic [$clog2(RAS_DEPTH):0] ras_count_o,
   output logic                       ras_overflow_o,
   output logic                       ras_underflow_o
);

   localparam int unsigned      PW      = $clog2(RAS_DEPTH);
   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);
   localparam logic [PW:0]      FULL    = (PW+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] ras [RAS_DEPTH];
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    top;
   logic             active;
   logic             do_ret;
   logic             do_call;

   assign pc_plus_o = pc_o + STEP_W;
   assign top       = ptr - PW'(1);
   // a branch or stall squashes every control-flow request in that cycle
   assign active    = !branch_taken_i && !stall_i;
   assign do_ret    = active && ret_i;
   assign do_call   = active && call_i && !ret_i;

   // circular buffer: when full, the push lands on the oldest entry
   always_ff @(posedge clk) begin
      if (do_call)
         ras[ptr] <= pc_plus_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_o            <= RESET_W;
         ptr             <= '0;
         ras_count_o     <= '0;
         ras_overflow_o  <= 1'b0;
         ras_underflow_o <= 1'b0;
      end else begin
         ras_overflow_o  <= 1'b0;
         ras_underflow_o <= 1'b0;
         if (branch_taken_i) begin
            pc_o <= branch_target_i;
         end else if (stall_i) begin
            pc_o <= pc_o;
         end else if (do_ret) begin
            if (ras_count_o != '0) begin
               pc_o        <= ras[top];
               ptr         <= top;
               ras_count_o <= ras_count_o - 1'b1;
            end else begin
               pc_o            <= pc_plus_o;
               ras_underflow_o <= 1'b1;
            end
         end else if (do_call) begin
            pc_o <= jump_target_i;
            ptr  <= ptr + PW'(1);
            if (ras_count_o == FULL)
               ras_overflow_o <= 1'b1;
            else
               ras_count_o <= ras_count_o + 1'b1;
         end else if (jump_i) begin
            pc_o <= jump_target_i;
         end else begin
            pc_o <= pc_plus_o;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (32-bit step 1, plus 8-bit step 4 wrap instance)
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch, jump, call, ret;
   logic [31:0] btgt, jtgt;
   logic [31:0] pc, pc_plus;
   logic [2:0]  cnt;
   logic        ovf, unf;

   logic        z1 = 1'b0;
   logic [7:0]  z8 = 8'h00;
   logic [7:0]  pc8, pc8_plus;
   logic [2:0]  cnt8;
   logic        ovf8, unf8;

   int pass_cnt = 0;
   int check_cnt = 0;

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
      logic [7:0]  pc8;
   } exp_t;
   exp_t sb_q[$];

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic [7:0]  m_pc8;

   always #5 clk = ~clk;

   pc_sequencer #(.WIDTH(32), .STEP(1), .RESET_PC('h100), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(branch),
      .branch_target_i(btgt), .jump_i(jump), .call_i(call), .ret_i(ret),
      .jump_target_i(jtgt), .pc_o(pc), .pc_plus_o(pc_plus), .ras_count_o(cnt),
      .ras_overflow_o(ovf), .ras_underflow_o(unf)
   );

   pc_sequencer #(.WIDTH(8), .STEP(4), .RESET_PC('hF4), .RAS_DEPTH(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .stall_i(z1), .branch_taken_i(z1),
      .branch_target_i(z8), .jump_i(z1), .call_i(z1), .ret_i(z1),
      .jump_target_i(z8), .pc_o(pc8), .pc_plus_o(pc8_plus), .ras_count_o(cnt8),
      .ras_overflow_o(ovf8), .ras_underflow_o(unf8)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_outputs(input exp_t e);
      check_eq("pc", pc, e.pc);
      check_eq("pc_plus", pc_plus, e.pc + 32'd1);
      check_eq("ras_count", {29'd0, cnt}, {29'd0, e.cnt});
      check_eq("overflow", {31'd0, ovf}, {31'd0, e.ovf});
      check_eq("underflow", {31'd0, unf}, {31'd0, e.unf});
      check_eq("pc8", {24'd0, pc8}, {24'd0, e.pc8});
      check_eq("pc8_plus", {24'd0, pc8_plus}, {24'd0, e.pc8 + 8'd4});
      check_eq("pc8_side", {29'd0, cnt8, ovf8, unf8}, 32'd0);
   endtask

   task automatic model_reset();
      m_pc  = 32'h100;
      m_pc8 = 8'hF4;
      m_ras.delete();
   endtask

   // drive one cycle of requests, predict the result, then compare one cycle later
   task automatic step(input logic b, input logic s, input logic j, input logic c,
                       input logic r, input logic [31:0] bt, input logic [31:0] jt);
      exp_t e;
      logic [31:0] nxt;
      branch = b; stall = s; jump = j; call = c; ret = r; btgt = bt; jtgt = jt;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      nxt = m_pc + 32'd1;
      if (b) m_pc = bt;
      else if (s) m_pc = m_pc;
      else if (r) begin
         if (m_ras.size() > 0) m_pc = m_ras.pop_back();
         else begin m_pc = nxt; e.unf = 1'b1; end
      end else if (c) begin
         m_ras.push_back(nxt);
         if (m_ras.size() > 4) begin void'(m_ras.pop_front()); e.ovf = 1'b1; end
         m_pc = jt;
      end else if (j) m_pc = jt;
      else m_pc = nxt;
      m_pc8 = m_pc8 + 8'd4;
      e.pc  = m_pc;
      e.cnt = 3'(m_ras.size());
      e.pc8 = m_pc8;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_outputs(sb_q.pop_front());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      exp_t e0;
      rst_n = 1'b0;
      {stall, branch, jump, call, ret} = '0;
      btgt = '0;
      jtgt = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      e0 = '{pc: 32'h100, cnt: 3'd0, ovf: 1'b0, unf: 1'b0, pc8: 8'hF4};
      check_outputs(e0);
      rst_n = 1'b1;

      idle(3);                                  // includes 8-bit wrap FC -> 00
      step(0, 0, 1, 0, 0, 0, 32'h200);
      repeat (3) step(0, 1, 1, 0, 0, 0, 32'h400);
      idle(1);
      step(1, 1, 0, 0, 0, 32'h80, 0);
      step(1, 1, 0, 1, 0, 32'h84, 32'h999);

      step(0, 0, 1, 0, 0, 0, 32'h10);
      step(0, 0, 0, 1, 0, 0, 32'h50);
      idle(2);
      step(0, 0, 0, 1, 0, 0, 32'h90);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);

      step(0, 0, 0, 1, 0, 0, 32'h300);
      step(0, 0, 0, 1, 1, 0, 32'h777);        // ret wins over call
      step(0, 0, 1, 1, 0, 0, 32'h310);        // call wins over jump
      step(0, 0, 0, 0, 1, 0, 0);

      step(0, 0, 1, 0, 0, 0, 32'hA00);
      step(0, 0, 0, 1, 0, 0, 32'hB00);
      step(0, 0, 0, 1, 0, 0, 32'hC00);
      step(0, 0, 0, 1, 0, 0, 32'hD00);
      step(0, 0, 0, 1, 0, 0, 32'hE00);
      step(0, 0, 0, 1, 0, 0, 32'hF00);        // overflow
      step(0, 1, 0, 1, 0, 0, 32'h123);        // stalled call at full: no pulse
      step(1, 0, 0, 1, 0, 32'hE00, 32'h456);  // branch squashes call
      repeat (4) step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);              // underflow
      idle(1);

      for (int i = 0; i < 40; i++)
         step($urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(3) == 0,
              $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom, $urandom);

      step(0, 0, 0, 1, 0, 0, 32'h40);
      step(0, 0, 0, 1, 0, 0, 32'h60);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_rst_pc", pc, 32'h100);
      check_eq("async_rst_cnt", {29'd0, cnt}, 32'd0);
      check_eq("async_rst_pc8", {24'd0, pc8}, 32'hF4);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      step(0, 0, 0, 0, 1, 0, 0);              // RAS emptied by reset: underflow

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
